// File: rtl/distribute_feeder_seq.sv
// Circular FIFO feeding a distribute node, with a registered output stage that is frozen by i_hold.
// Optional macro DISTRIBUTE_FEEDER_DROP_NA_EN: accept but discard entries whose command is NA (all zero).
module distribute_feeder_seq #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COMMMAND_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_data_bus,
  input  logic [COMMMAND_WIDTH-1:0]    i_cmd,
  output logic                         o_ready,
  input  logic                         i_hold,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data_bus,
  output logic [COMMMAND_WIDTH-1:0]    o_cmd,
  output logic                         o_en,
  output logic [$clog2(FIFO_DEPTH):0]  o_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = COMMMAND_WIDTH + DATA_WIDTH;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept;
  logic             store;
  logic             pop;

  // Ready decodes registered occupancy only, so no path from i_hold/i_valid
  assign o_ready = (o_count < CNT_W'(FIFO_DEPTH));
  assign o_en    = ~i_hold;
  assign accept  = i_valid & o_ready;
  assign pop     = ~i_hold & (o_count != '0);

`ifdef DISTRIBUTE_FEEDER_DROP_NA_EN
  assign store = accept & (i_cmd != '0);
`else
  assign store = accept;
`endif

  // Storage array carries no reset; occupancy decides what is meaningful
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= {i_cmd, i_data_bus};
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      o_count <= o_count + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // Output stage: load head, or a dummy when empty; hold freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end else if (!i_hold) begin
      if (pop) begin
        o_valid               <= 1'b1;
        {o_cmd, o_data_bus}   <= mem[rd_ptr];
      end else begin
        o_valid    <= 1'b0;
        o_data_bus <= '0;
        o_cmd      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_distribute_feeder_seq.sv
// Self-checking bench for distribute_feeder_seq against a queue-based reference model.
module tb_distribute_feeder_seq;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data_bus;
  logic [1:0]  i_cmd;
  logic        o_ready;
  logic        i_hold;
  logic        o_valid;
  logic [31:0] o_data_bus;
  logic [1:0]  o_cmd;
  logic        o_en;
  logic [2:0]  o_count;

  ent_t        q[$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_cmd;

  int n_cmp;
  int n_fail;

  distribute_feeder_seq #(
    .DATA_WIDTH    (32),
    .COMMMAND_WIDTH(2),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data_bus(i_data_bus),
    .i_cmd     (i_cmd),
    .o_ready   (o_ready),
    .i_hold    (i_hold),
    .o_valid   (o_valid),
    .o_data_bus(o_data_bus),
    .o_cmd     (o_cmd),
    .o_en      (o_en),
    .o_count   (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the reference model, sample 1ns after the edge
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] c, input logic h);
    ent_t e;
    bit   acc;
    i_valid    = v;
    i_data_bus = d;
    i_cmd      = c;
    i_hold     = h;
    acc = v && (q.size() < DEPTH);
`ifdef DISTRIBUTE_FEEDER_DROP_NA_EN
    acc = acc && (c != 2'b00);
`endif
    if (!h) begin
      if (q.size() != 0) begin
        e       = q.pop_front();
        m_valid = 1'b1;
        m_data  = e.data;
        m_cmd   = e.cmd;
      end else begin
        m_valid = 1'b0;
        m_data  = '0;
        m_cmd   = '0;
      end
    end
    if (acc) q.push_back('{cmd: c, data: d});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_cmd = '0; i_hold = 1'b0;
    m_valid = 1'b0; m_data = '0; m_cmd = '0; q.delete();
    #3;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_data_bus !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_data_bus); end
    n_cmp++; if (o_cmd !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b expected 00", o_cmd); end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_single();
    step(1'b1, 32'hAAAAAAAA, 2'b01, 1'b0);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_write_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_write_count: got %0d expected 1", o_count); end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", o_valid); end
    n_cmp++; if (o_cmd !== 2'b01) begin n_fail++; $display("FAIL single_out_cmd: got %b expected 01", o_cmd); end
    n_cmp++; if (o_data_bus !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL single_out_data: got %h expected aaaaaaaa", o_data_bus); end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_data_bus !== 32'h0) begin n_fail++; $display("FAIL single_after_data: got %h expected 0", o_data_bus); end
  endtask

  task automatic test_full_hold();
    logic [31:0] d [5];
    logic [1:0]  c [5];
    for (int i = 0; i < 5; i++) begin
      d[i] = $urandom;
      c[i] = 2'($urandom_range(1, 3));
      step(1'b1, d[i], c[i], 1'b1);
    end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", o_count); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_hold_valid: got %b expected 0", o_valid); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 2'b00, 1'b0);
      n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== d[i] || o_cmd !== c[i]) begin
        n_fail++; $display("FAIL full_drain_%0d: got v=%b %h/%b expected v=1 %h/%b", i, o_valid, o_data_bus, o_cmd, d[i], c[i]);
      end
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL full_fifth_dropped: got v=%b data=%h expected v=0", o_valid, o_data_bus); end
  endtask

  task automatic test_hold_freeze();
    step(1'b1, 32'hBBBBBBBB, 2'b11, 1'b0);
    step(1'b1, 32'h12345678, 2'b10, 1'b0);
    n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== 32'hBBBBBBBB || o_cmd !== 2'b11) begin
      n_fail++; $display("FAIL freeze_head: got v=%b %h/%b expected v=1 bbbbbbbb/11", o_valid, o_data_bus, o_cmd);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 2'b00, 1'b1);
      n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== 32'hBBBBBBBB || o_cmd !== 2'b11) begin
        n_fail++; $display("FAIL freeze_hold_%0d: got v=%b %h/%b expected v=1 bbbbbbbb/11", i, o_valid, o_data_bus, o_cmd);
      end
      n_cmp++; if (o_en !== 1'b0) begin n_fail++; $display("FAIL freeze_en_%0d: got %b expected 0", i, o_en); end
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_en !== 1'b1) begin n_fail++; $display("FAIL freeze_en_release: got %b expected 1", o_en); end
    n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== 32'h12345678 || o_cmd !== 2'b10) begin
      n_fail++; $display("FAIL freeze_advance: got v=%b %h/%b expected v=1 12345678/10", o_valid, o_data_bus, o_cmd);
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_stream();
    step(1'b1, 32'd0, 2'b01, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 32'(i), 2'b01, 1'b0);
      n_cmp++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL stream_count_%0d: got %0d expected 1", i, o_count); end
      n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== 32'(i - 1)) begin
        n_fail++; $display("FAIL stream_data_%0d: got v=%b %0d expected v=1 %0d", i, o_valid, o_data_bus, i - 1);
      end
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== 1'b1 || o_data_bus !== 32'd9) begin
      n_fail++; $display("FAIL stream_last: got v=%b %0d expected v=1 9", o_valid, o_data_bus);
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'hCAFE0001, 2'b01, 1'b0);
    step(1'b1, 32'hCAFE0002, 2'b10, 1'b0);
    step(1'b1, 32'hCAFE0003, 2'b11, 1'b1);
    step(1'b1, 32'hCAFE0004, 2'b01, 1'b1);
    i_valid = 1'b0;
    n_cmp++; if (o_count !== 3'd3 || o_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got count=%0d v=%b expected count=3 v=1", o_count, o_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0 || o_cmd !== 2'b00) begin
      n_fail++; $display("FAIL midrst_outputs: got v=%b %h/%b expected all zero", o_valid, o_data_bus, o_cmd);
    end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", o_ready); end
    #2;
    rst_n = 1'b1;
    q.delete(); m_valid = 1'b0; m_data = '0; m_cmd = '0;
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0) begin
      n_fail++; $display("FAIL midrst_first_out: got v=%b %h expected v=0 0", o_valid, o_data_bus);
    end
  endtask

  task automatic test_na_cmd();
    logic [2:0]  exp_cnt;
    logic        exp_v;
    logic [31:0] exp_d;
`ifdef DISTRIBUTE_FEEDER_DROP_NA_EN
    exp_cnt = 3'd0; exp_v = 1'b0; exp_d = 32'h0;
`else
    exp_cnt = 3'd1; exp_v = 1'b1; exp_d = 32'h5A5A5A5A;
`endif
    i_valid = 1'b1; i_data_bus = 32'h5A5A5A5A; i_cmd = 2'b00; i_hold = 1'b0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL na_ready: got %b expected 1", o_ready); end
    step(1'b1, 32'h5A5A5A5A, 2'b00, 1'b0);
    n_cmp++; if (o_count !== exp_cnt) begin n_fail++; $display("FAIL na_count: got %0d expected %0d", o_count, exp_cnt); end
    step(1'b0, 32'h0, 2'b00, 1'b0);
    n_cmp++; if (o_valid !== exp_v || o_data_bus !== exp_d || o_cmd !== 2'b00) begin
      n_fail++; $display("FAIL na_out: got v=%b %h/%b expected v=%b %h/00", o_valid, o_data_bus, o_cmd, exp_v, exp_d);
    end
    step(1'b0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] exp_cnt;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3));
      exp_cnt = 3'(q.size());
      n_cmp++; if (o_valid !== m_valid || o_data_bus !== m_data || o_cmd !== m_cmd) begin
        n_fail++; $display("FAIL rand_out_%0d: got v=%b %h/%b expected v=%b %h/%b", i, o_valid, o_data_bus, o_cmd, m_valid, m_data, m_cmd);
      end
      n_cmp++; if (o_count !== exp_cnt) begin n_fail++; $display("FAIL rand_count_%0d: got %0d expected %0d", i, o_count, exp_cnt); end
      n_cmp++; if (o_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready_%0d: got %b expected %b", i, o_ready, q.size() < DEPTH); end
      n_cmp++; if (o_en !== ~i_hold) begin n_fail++; $display("FAIL rand_en_%0d: got %b expected %b", i, o_en, ~i_hold); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_full_hold();
    test_hold_freeze();
    test_stream();
    test_reset_mid();
    test_na_cmd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
